// File: rtl/touch_event_sequencer.sv
// Periodically samples the touch core's decoded outputs, queues changed samples
// as event words in a FIFO and exposes them to the CPU over Avalon-MM with a level interrupt.
module touch_event_sequencer #(
    parameter int SAMPLE_DIV = 50000,
    parameter int DEPTH      = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  touch_count,
    input  logic [9:0]  x1,
    input  logic [8:0]  y1,
    input  logic [7:0]  gest_code,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPARE,
        S_PUSH
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_snap;
    logic [31:0]    r_last;
    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    logic           r_overflow;
    logic           r_enable;
    logic           r_irq_en;
    logic [8:0]     r_thresh;
    logic [31:0]    r_readdata;
    logic           r_irq;

    logic [31:0]    w_word;
    logic           w_tick;
    logic           w_empty;
    logic           w_full;
    logic [8:0]     w_level9;
    logic           w_wr_ctrl;
    logic           w_wr_thresh;
    logic           w_flush;
    logic           w_clr_ovf;
    logic           w_pop;
    logic           w_push_req;
    logic           w_push;
    logic           w_drop;
    logic           w_unused_wdata;

    assign w_word      = {touch_count, gest_code, 1'b0, y1, x1};
    assign w_tick      = r_enable && (r_cnt == CW'(SAMPLE_DIV - 1));
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_level9    = 9'(r_level);

    assign w_wr_ctrl   = write && (address == 2'd2);
    assign w_wr_thresh = write && (address == 2'd3);
    assign w_flush     = w_wr_ctrl && writedata[2];
    assign w_clr_ovf   = w_wr_ctrl && writedata[3];

    // Flush outranks both the CPU pop and the sequencer push in the same cycle.
    assign w_pop       = read && (address == 2'd0) && !w_empty && !w_flush;
    assign w_push_req  = (r_state == S_PUSH) && !w_flush;
    assign w_push      = w_push_req && !w_full;
    assign w_drop      = w_push_req && w_full;

    assign w_unused_wdata = ^writedata[31:9];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!r_enable || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_last  <= '0;
        end else if (w_flush) begin
            r_state <= S_IDLE;
            r_last  <= '0;
        end else begin
            case (r_state)
                S_IDLE:    if (w_tick) r_state <= S_CAPTURE;
                S_CAPTURE: r_state <= S_COMPARE;
                S_COMPARE: r_state <= (r_snap != r_last) ? S_PUSH : S_IDLE;
                S_PUSH: begin
                    // A dropped event leaves r_last alone so the change is retried.
                    if (!w_full) r_last <= r_snap;
                    r_state <= S_IDLE;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_CAPTURE) r_snap <= w_word;
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= r_snap;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= 9'd1;
        end else begin
            if (w_drop)         r_overflow <= 1'b1;
            else if (w_clr_ovf) r_overflow <= 1'b0;
            if (w_wr_ctrl) begin
                r_enable <= writedata[0];
                r_irq_en <= writedata[1];
            end
            if (w_wr_thresh) r_thresh <= writedata[8:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (read) begin
                case (address)
                    2'd0:    r_readdata <= w_empty ? 32'd0 : r_mem[r_rptr];
                    2'd1:    r_readdata <= {18'd0, r_irq_en, r_enable, r_overflow,
                                            w_full, w_empty, w_level9};
                    2'd2:    r_readdata <= {30'd0, r_irq_en, r_enable};
                    default: r_readdata <= {23'd0, r_thresh};
                endcase
            end
            r_irq <= r_irq_en && (r_thresh != 9'd0) && (w_level9 >= r_thresh);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_touch_event_sequencer.sv
// Bench for touch_event_sequencer: directed scenarios plus randomized sample periods
// checked against a queue-based model of the event stream.
module tb_touch_event_sequencer;

    localparam int SDIV  = 8;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  touch_count = '0;
    logic [9:0]  x1 = '0;
    logic [8:0]  y1 = '0;
    logic [7:0]  gest_code = '0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    touch_event_sequencer #(.SAMPLE_DIV(SDIV), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .touch_count(touch_count), .x1(x1), .y1(y1), .gest_code(gest_code),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_last = '0;
    logic        m_ovf = 1'b0;
    logic        m_en = 1'b0;
    logic        m_ien = 1'b0;
    logic [8:0]  m_thresh = 9'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        step(1);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        step(1);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic set_in(input logic [3:0] tc, input logic [9:0] x, input logic [8:0] y,
                          input logic [7:0] g);
        touch_count = tc; x1 = x; y1 = y; gest_code = g;
    endtask

    function automatic logic [31:0] ctrl_word(input logic flush, input logic clr);
        return {28'd0, clr, flush, m_ien, m_en};
    endfunction

    function automatic logic [31:0] exp_status();
        int lvl;
        lvl = m_q.size();
        return {18'd0, m_ien, m_en, m_ovf, (lvl == DEPTH), (lvl == 0), 9'(lvl)};
    endfunction

    function automatic logic exp_irq();
        return m_ien && (m_thresh != 9'd0) && (m_q.size() >= int'(m_thresh));
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_q.size() == 0) return 32'd0;
        return m_q.pop_front();
    endfunction

    // Entered 1 time unit after a tick edge; leaves 1 time unit after the next tick edge.
    // Inputs currently applied are the sample for this tick; the new ones are applied at the end.
    task automatic run_period(input bit coinc, input int act, input logic [3:0] tc,
                              input logic [9:0] x, input logic [8:0] y, input logic [7:0] g,
                              input bit flush_cmp);
        logic [31:0] d;
        logic [31:0] snap;
        logic [31:0] expd;
        bit          full_b;
        snap = {touch_count, gest_code, 1'b0, y1, x1};
        if (flush_cmp) begin
            step(1);
            bus_write(2'd2, ctrl_word(1'b1, 1'b0));
            m_q.delete();
            m_last = '0;
            step(1);
        end else begin
            step(2);
            full_b = (m_q.size() == DEPTH);
            if (coinc) begin
                bus_read(2'd0, d);
                expd = model_pop();
                chk("data_coinc", d, expd);
            end else begin
                step(1);
            end
            if (snap != m_last) begin
                if (!full_b) begin
                    m_q.push_back(snap);
                    m_last = snap;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        step(1);
        chk("irq", 32'(irq), 32'(exp_irq()));
        bus_read(2'd1, d);
        chk("status", d, exp_status());
        case (act)
            1: begin
                bus_read(2'd0, d);
                expd = model_pop();
                chk("data", d, expd);
                step(1);
                chk("irq_after_pop", 32'(irq), 32'(exp_irq()));
            end
            2: begin
                bus_write(2'd2, ctrl_word(1'b0, 1'b1));
                m_ovf = 1'b0;
                bus_read(2'd1, d);
                chk("status_after_clr", d, exp_status());
            end
            3: begin
                m_thresh = 9'($urandom_range(0, 4));
                bus_write(2'd3, {23'd0, m_thresh});
                bus_read(2'd3, d);
                chk("thresh", d, {23'd0, m_thresh});
            end
            4: begin
                bus_read(2'd2, d);
                chk("control", d, {30'd0, m_ien, m_en});
                step(1);
            end
            default: step(2);
        endcase
        set_in(tc, x, y, g);
        step(1);
    endtask

    initial begin
        logic [31:0] d;
        step(3);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        step(1);
        bus_read(2'd1, d);
        chk("rst_status", d, exp_status());
        bus_read(2'd3, d);
        chk("rst_thresh", d, 32'd1);
        bus_read(2'd2, d);
        chk("rst_control", d, 32'd0);

        set_in(4'd1, 10'd100, 9'd50, 8'd0);
        m_en = 1'b1;
        m_ien = 1'b1;
        bus_write(2'd2, ctrl_word(1'b0, 1'b0));
        step(SDIV);

        run_period(0, 0, 4'd1, 10'd100, 9'd50, 8'd0, 0);
        repeat (5) run_period(0, 0, 4'd1, 10'd100, 9'd50, 8'd0, 0);
        run_period(0, 1, 4'd1, 10'd100, 9'd50, 8'd0, 0);

        // Fill past capacity; the final period clears overflow and parks the inputs on the
        // last accepted word so no further events are generated.
        for (int i = 0; i < 10; i++)
            run_period(0, 0, 4'd2, 10'(200 + i), 9'd60, 8'h11, 0);
        run_period(0, 2, 4'd2, 10'd207, 9'd60, 8'h11, 0);
        repeat (9) run_period(0, 1, 4'd2, 10'd207, 9'd60, 8'h11, 0);

        for (int i = 0; i < 4; i++)
            run_period(0, 0, 4'd3, 10'(300 + i), 9'd5, 8'h22, 0);
        run_period(1, 0, 4'd3, 10'd304, 9'd5, 8'h22, 0);
        run_period(0, 0, 4'd3, 10'd304, 9'd5, 8'h22, 1);
        run_period(0, 0, 4'd3, 10'd304, 9'd5, 8'h22, 0);

        for (int i = 0; i < 60; i++) begin
            bit fl;
            bit co;
            fl = ($urandom_range(0, 9) == 0);
            co = !fl && ($urandom_range(0, 3) == 0);
            run_period(co, int'($urandom_range(0, 4)),
                       4'($urandom_range(0, 2)), 10'($urandom_range(0, 2) * 300),
                       9'($urandom_range(0, 1) * 77), 8'($urandom_range(0, 1) * 42), fl);
        end

        // Asynchronous reset in the middle of a cycle.
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        step(2);
        resetn = 1'b1;
        m_q.delete();
        m_last = '0;
        m_ovf = 1'b0;
        m_en = 1'b0;
        m_ien = 1'b0;
        m_thresh = 9'd1;
        step(1);
        bus_read(2'd1, d);
        chk("post_rst_status", d, exp_status());
        bus_read(2'd3, d);
        chk("post_rst_thresh", d, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
